lsu_queue: RTL

Parametrised load/store unit for the pipelined core. It replaces the single-outstanding `mem_stage` handshake with an in-order buffer of up to `DEPTH_P` memory operations, so execute can keep issuing while data memory is busy. It sits between the execute stage (requests, register writeback) and the data memory port (valid/yumi request and response handshakes). It also supports a pipeline flush that squashes pending operations without violating the memory protocol.

---
 rtl/lsu_queue_pkg.sv | 22 ++
 rtl/lsu_queue_if.sv | 41 ++++
 rtl/lsu_queue_buf_ram.sv | 45 ++++
 rtl/lsu_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/lsu_queue_pkg.sv
// lsu_queue_pkg: shared entry types and pointer sizing for the load/store queue
// Contents: LSU_ADDR_W / LSU_RF_W payload widths (lsu_queue parameters default to these
// and must match them), lsu_req_s (fields presented to dmem), lsu_entry_s (full buffer
// entry), lsu_ptr_w() (pointer width including the wrap bit).
package lsu_queue_pkg;
   localparam int LSU_ADDR_W = 32;
   localparam int LSU_RF_W = 5;
   typedef struct packed {
      logic                  wen;
      logic                  is_byte;
      logic [LSU_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
   } lsu_req_s;
   typedef struct packed {
      lsu_req_s            req;
      logic [LSU_RF_W-1:0] rd;
      logic                kill;
   } lsu_entry_s;
   function automatic int lsu_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/lsu_queue_if.sv
// lsu_queue_if: execute-side request, flush, dmem request/response and writeback signals
// Modports: slave = the LSU itself, master = the environment (execute, dmem, regfile).
interface lsu_queue_if #(
   parameter int ADDR_W_P    = 32,
   parameter int RF_ADDR_W_P = 5
);
   logic                   req_valid_i;
   logic                   req_ready_o;
   logic                   req_wen_i;
   logic                   req_byte_i;
   logic [ADDR_W_P-1:0]    req_addr_i;
   logic [31:0]            req_wdata_i;
   logic [RF_ADDR_W_P-1:0] req_rd_i;
   logic                   flush_i;
   logic                   mem_valid_o;
   logic                   mem_wen_o;
   logic                   mem_byte_o;
   logic [ADDR_W_P-1:0]    mem_addr_o;
   logic [31:0]            mem_wdata_o;
   logic                   mem_yumi_i;
   logic                   mem_rvalid_i;
   logic [31:0]            mem_rdata_i;
   logic                   mem_ryumi_o;
   logic                   wb_valid_o;
   logic [RF_ADDR_W_P-1:0] wb_rd_o;
   logic [31:0]            wb_data_o;
   logic                   wb_ready_i;

   modport slave (
      input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, req_rd_i, flush_i,
             mem_yumi_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
      output req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
             mem_ryumi_o, wb_valid_o, wb_rd_o, wb_data_o
   );
   modport master (
      output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, req_rd_i, flush_i,
             mem_yumi_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
      input  req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
             mem_ryumi_o, wb_valid_o, wb_rd_o, wb_data_o
   );
endinterface

// File: rtl/lsu_queue_buf_ram.sv
// lsu_queue_buf_ram: DEPTH_P-entry storage, one write port, async reads at iss and head,
// and a kill-range set used by flush
// Ports: clk; we/waddr/wdata write; kill_en/kill_lo/kill_len mark kill_len entries from
// kill_lo (circular); iss_idx -> iss_req; head_idx -> head_* fields.
module lsu_queue_buf_ram import lsu_queue_pkg::*; #(
   parameter int DEPTH_P = 4
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH_P)-1:0] waddr,
   input  lsu_entry_s                 wdata,
   input  logic                       kill_en,
   input  logic [$clog2(DEPTH_P)-1:0] kill_lo,
   input  logic [$clog2(DEPTH_P):0]   kill_len,
   input  logic [$clog2(DEPTH_P)-1:0] iss_idx,
   input  logic [$clog2(DEPTH_P)-1:0] head_idx,
   output lsu_req_s                   iss_req,
   output logic                       head_wen,
   output logic                       head_byte,
   output logic [LSU_RF_W-1:0]        head_rd,
   output logic                       head_kill
);
   localparam int AW = $clog2(DEPTH_P);
   lsu_entry_s mem [DEPTH_P];
   logic [DEPTH_P-1:0] hit;

   // entry i is in the range when its circular distance from kill_lo is below kill_len
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH_P; i++)
         hit[i] = {1'b0, AW'(i) - kill_lo} < kill_len;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH_P; i++)
         if (we && waddr == AW'(i)) mem[i] <= wdata;
         else if (kill_en && hit[i]) mem[i].kill <= 1'b1;
   end

   assign iss_req   = mem[iss_idx].req;
   assign head_wen  = mem[head_idx].req.wen;
   assign head_byte = mem[head_idx].req.is_byte;
   assign head_rd   = mem[head_idx].rd;
   assign head_kill = mem[head_idx].kill;
endmodule

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store buffer between execute and the data memory port
// Ports: clk, reset (async, active-high); bus (lsu_queue_if.slave) carries the request,
// flush, dmem request/response and writeback handshakes; count_o occupied entries,
// idle_o empty, error_o sticky response-with-nothing-outstanding flag.
module lsu_queue import lsu_queue_pkg::*; #(
   parameter int DEPTH_P     = 4,
   parameter int ADDR_W_P    = LSU_ADDR_W,
   parameter int RF_ADDR_W_P = LSU_RF_W,
   parameter bit SEXT_BYTE_P = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   lsu_queue_if.slave               bus,
   output logic [$clog2(DEPTH_P):0] count_o,
   output logic                     idle_o,
   output logic                     error_o
);
   localparam int PW = lsu_ptr_w(DEPTH_P);
   localparam int AW = PW - 1;
   logic [PW-1:0] tail, iss, head, tail_n, count;
   logic full, accept, issue, outst, live;
   lsu_entry_s e_new;
   lsu_req_s e_iss;
   logic h_wen, h_byte, h_kill;
   logic [LSU_RF_W-1:0] h_rd;

   assign count   = tail - head;
   assign count_o = count;
   assign idle_o  = count == '0;
   assign full    = count == PW'(DEPTH_P);

   assign bus.req_ready_o = !full && !bus.flush_i && !reset;
   assign accept = bus.req_valid_i && bus.req_ready_o;
   assign e_new = '{req: '{wen: bus.req_wen_i, is_byte: bus.req_byte_i,
                           addr: bus.req_addr_i, wdata: bus.req_wdata_i},
                    rd: bus.req_rd_i, kill: 1'b0};

   assign bus.mem_valid_o = iss != tail;
   assign bus.mem_wen_o   = e_iss.wen;
   assign bus.mem_byte_o  = e_iss.is_byte;
   assign bus.mem_addr_o  = ADDR_W_P'(e_iss.addr);
   assign bus.mem_wdata_o = e_iss.wdata;
   assign issue = bus.mem_valid_o && bus.mem_yumi_i;

   // only entries between head and iss can own a response
   assign outst = head != iss;
   assign live  = !h_wen && !h_kill;
   assign bus.mem_ryumi_o = bus.mem_rvalid_i && outst && (!live || bus.wb_ready_i);
   assign bus.wb_valid_o  = bus.mem_rvalid_i && outst && live && h_rd != '0;
   assign bus.wb_rd_o     = RF_ADDR_W_P'(h_rd);
   assign bus.wb_data_o   = h_byte ? {{24{SEXT_BYTE_P & bus.mem_rdata_i[7]}}, bus.mem_rdata_i[7:0]}
                                   : bus.mem_rdata_i;

   // a presented entry survives flush (killed) whether or not it is taken this cycle
   assign tail_n = bus.mem_valid_o ? iss + 1'b1 : iss;

   lsu_queue_buf_ram #(.DEPTH_P(DEPTH_P)) u_ram (
      .clk       (clk),
      .we        (accept),
      .waddr     (tail[AW-1:0]),
      .wdata     (e_new),
      .kill_en   (bus.flush_i),
      .kill_lo   (head[AW-1:0]),
      .kill_len  (tail_n - head),
      .iss_idx   (iss[AW-1:0]),
      .head_idx  (head[AW-1:0]),
      .iss_req   (e_iss),
      .head_wen  (h_wen),
      .head_byte (h_byte),
      .head_rd   (h_rd),
      .head_kill (h_kill)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tail    <= '0;
         iss     <= '0;
         head    <= '0;
         error_o <= 1'b0;
      end else begin
         if (bus.flush_i) tail <= tail_n;
         else if (accept) tail <= tail + 1'b1;
         if (issue) iss <= iss + 1'b1;
         if (bus.mem_ryumi_o) head <= head + 1'b1;
         if (bus.mem_rvalid_i && !outst) error_o <= 1'b1;
      end
   end
endmodule
